// File: rtl/tt_arb_pkg.sv
// -----------------------------------------------------------------------------
// tt_arb_pkg
//   Shared types and constants for the output-bus arbiter.
//   - state_t    : arbiter FSM encoding (IDLE / BUSY)
//   - *_DEF      : default parameter values
//   - idx_w(n)   : width of an index into n entries, never below 1 bit
// -----------------------------------------------------------------------------
package tt_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int unsigned N_REQ_DEF     = 4;
   localparam int unsigned DATA_W_DEF    = 8;
   localparam int unsigned MAX_BURST_DEF = 4;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-priority search: returns the first set bit of req
//   at or after index ptr, wrapping cyclically at N_REQ.
//   Ports:
//     req   in  N_REQ  request vector
//     ptr   in  IW     starting index (assumed < N_REQ)
//     found out 1      any bit of req set
//     idx   out IW     selected index (0 when nothing found)
// -----------------------------------------------------------------------------
module rr_pick
   import tt_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned IW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic             found,
   output logic [IW-1:0]    idx
);

   logic [IW:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         // modulo N_REQ, not modulo 2**IW
         cand = {1'b0, ptr} + (IW+1)'(k);
         if (cand >= (IW+1)'(N_REQ)) begin
            cand = cand - (IW+1)'(N_REQ);
         end
         if (!found && req[cand[IW-1:0]]) begin
            found = 1'b1;
            idx   = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/tt_output_arbiter.sv
// -----------------------------------------------------------------------------
// tt_output_arbiter
//   Round-robin arbiter sharing one registered output beat stream between
//   N_REQ valid/ready requesters. A grant lasts up to MAX_BURST beats, then
//   priority rotates to the requester after the granted one.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     ena        design enable; low blocks new grants and transfers
//     req_valid  per-requester beat valid
//     req_data   flattened beats, requester i at [i*DATA_W +: DATA_W]
//     req_ready  per-requester accept
//     out_valid  output register holds an unconsumed beat
//     out_data   output beat
//     out_src    requester index that produced out_data
//     out_ready  downstream accept
//     busy       FSM is in BUSY
// -----------------------------------------------------------------------------
module tt_output_arbiter
   import tt_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = N_REQ_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ena,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [idx_w(N_REQ)-1:0]   out_src,
   input  logic                      out_ready,
   output logic                      busy
);

   localparam int unsigned IW = idx_w(N_REQ);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   state_t              state_q,     state_d;
   logic [IW-1:0]       rr_ptr_q,    rr_ptr_d;
   logic [IW-1:0]       grant_q,     grant_d;
   logic [CW-1:0]       beat_cnt_q,  beat_cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q,  out_data_d;
   logic [IW-1:0]       out_src_q,   out_src_d;

   logic                pick_found;
   logic [IW-1:0]       pick_idx;
   logic [IW-1:0]       next_ptr;
   logic [DATA_W-1:0]   sel_data;
   logic                take_ok;

   rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_q == IW'(i)) begin
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign next_ptr = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
   // output slot is free this cycle if empty or being drained
   assign take_ok  = ena & (~out_valid_q | out_ready);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      beat_cnt_d  = beat_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      req_ready   = '0;

      if (out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (ena && pick_found) begin
               grant_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            req_ready[grant_q] = take_ok;
            if (!ena || !req_valid[grant_q]) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
            end else if (take_ok) begin
               out_valid_d = 1'b1;
               out_data_d  = sel_data;
               out_src_d   = grant_q;
               beat_cnt_d  = beat_cnt_q + 1'b1;
               if (beat_cnt_q == CW'(MAX_BURST - 1)) begin
                  state_d  = IDLE;
                  rr_ptr_d = next_ptr;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         beat_cnt_q  <= beat_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_tt_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tt_output_arbiter
//   Directed bench for tt_output_arbiter. Two instances share the stimulus:
//   u4 uses MAX_BURST=4, u2 uses MAX_BURST=2 (round-robin sequence).
// -----------------------------------------------------------------------------
module tb_tt_output_arbiter;

   logic        clk = 1'b0;
   logic        rst, ena, out_ready;
   logic [3:0]  req_valid;
   logic [31:0] req_data;

   logic [3:0]  u4_req_ready, u2_req_ready;
   logic        u4_out_valid, u2_out_valid;
   logic [7:0]  u4_out_data,  u2_out_data;
   logic [1:0]  u4_out_src,   u2_out_src;
   logic        u4_busy,      u2_busy;

   int checks   = 0;
   int failures = 0;

   localparam logic       T2_V [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam logic       T2_B [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam logic [7:0] T2_D [9] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'hA4, 8'hA5, 8'h00};
   localparam logic [1:0] RR_SRC  [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
   localparam logic [7:0] RR_DATA [10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};

   always #5 clk = ~clk;

   tt_output_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(4)) u4 (
      .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid), .req_data(req_data),
      .req_ready(u4_req_ready), .out_valid(u4_out_valid), .out_data(u4_out_data),
      .out_src(u4_out_src), .out_ready(out_ready), .busy(u4_busy)
   );

   tt_output_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(2)) u2 (
      .clk(clk), .rst(rst), .ena(ena), .req_valid(req_valid), .req_data(req_data),
      .req_ready(u2_req_ready), .out_valid(u2_out_valid), .out_data(u2_out_data),
      .out_src(u2_out_src), .out_ready(out_ready), .busy(u2_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   initial begin
      int          cnt;
      int          nbeat;
      logic        hs;
      logic [3:0]  hsv;
      int          bc [4];
      logic [1:0]  got_src  [10];
      logic [7:0]  got_data [10];
      logic [7:0]  q [$];

      rst = 1'b1; ena = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;

      // reset then idle
      tick(); tick();
      rst = 1'b0;
      chk("rst_out_valid", 32'(u4_out_valid), 0);
      chk("rst_out_data",  32'(u4_out_data),  0);
      chk("rst_out_src",   32'(u4_out_src),   0);
      chk("rst_busy",      32'(u4_busy),      0);
      chk("rst_req_ready", 32'(u4_req_ready), 0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("idle_out_valid", 32'(u4_out_valid), 0);
         chk("idle_out_data",  32'(u4_out_data),  0);
         chk("idle_busy",      32'(u4_busy),      0);
         chk("idle_req_ready", 32'(u4_req_ready), 0);
      end

      // single requester 2, six beats, MAX_BURST=4
      cnt = 0;
      for (int k = 0; k < 9; k++) begin
         req_valid      = (cnt < 6) ? 4'b0100 : 4'b0000;
         req_data[16+:8] = 8'(8'hA0 + cnt);
         #1;
         hs = req_valid[2] & u4_req_ready[2];
         tick();
         if (hs) cnt++;
         chk("burst_out_valid", 32'(u4_out_valid), 32'(T2_V[k]));
         chk("burst_busy",      32'(u4_busy),      32'(T2_B[k]));
         if (T2_V[k]) begin
            chk("burst_out_data", 32'(u4_out_data), 32'(T2_D[k]));
            chk("burst_out_src",  32'(u4_out_src),  2);
         end
      end
      chk("burst_beats_taken", 32'(cnt), 6);

      // round-robin with all requesters valid, MAX_BURST=2 instance
      rst = 1'b1; req_valid = '0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) bc[i] = 0;
      nbeat = 0;
      for (int cyc = 0; cyc < 60 && nbeat < 10; cyc++) begin
         for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(16*i + bc[i]);
         req_valid = 4'hF;
         #1;
         hsv = u2_req_ready & req_valid;
         tick();
         for (int i = 0; i < 4; i++) if (hsv[i]) bc[i]++;
         if (u2_out_valid) begin
            got_src[nbeat]  = u2_out_src;
            got_data[nbeat] = u2_out_data;
            nbeat++;
         end
      end
      chk("rr_beat_count", 32'(nbeat), 10);
      for (int b = 0; b < nbeat; b++) begin
         chk("rr_src",  32'(got_src[b]),  32'(RR_SRC[b]));
         chk("rr_data", 32'(got_data[b]), 32'(RR_DATA[b]));
      end

      // backpressure mid-burst from requester 1
      rst = 1'b1; req_valid = '0; out_ready = 1'b1;
      tick();
      rst = 1'b0;
      cnt = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
         out_ready       = !(cyc >= 4 && cyc <= 8);
         req_valid       = (cnt < 4) ? 4'b0010 : 4'b0000;
         req_data[8+:8]  = 8'(8'h50 + cnt);
         #1;
         if (u4_out_valid && out_ready) q.push_back(u4_out_data);
         if (!out_ready) begin
            chk("bp_req_ready", 32'(u4_req_ready), 0);
            chk("bp_out_valid", 32'(u4_out_valid), 1);
            chk("bp_out_data",  32'(u4_out_data),  32'h52);
            chk("bp_out_src",   32'(u4_out_src),   1);
            chk("bp_busy",      32'(u4_busy),      1);
         end
         hs = req_valid[1] & u4_req_ready[1];
         tick();
         if (hs) cnt++;
         if (cyc == 9) begin
            chk("bp_burst_end_busy", 32'(u4_busy),     0);
            chk("bp_last_data",      32'(u4_out_data), 32'h53);
         end
      end
      chk("bp_taken",    32'(cnt),      4);
      chk("bp_consumed", 32'(q.size()), 4);
      for (int b = 0; b < q.size() && b < 4; b++) begin
         chk("bp_seq", 32'(q[b]), 32'(8'h50 + b));
      end
      out_ready = 1'b1;

      // early release of requester 3 (rr_ptr is 2 here)
      req_valid = 4'b1000; req_data[24+:8] = 8'h70;
      tick();
      chk("er_busy_grant", 32'(u4_busy),      1);
      chk("er_ready3",     32'(u4_req_ready), 32'b1000);
      tick();
      chk("er_out_data", 32'(u4_out_data),  32'h70);
      chk("er_out_src",  32'(u4_out_src),   3);
      req_valid = 4'b0011; req_data[0+:8] = 8'h80; req_data[8+:8] = 8'h90;
      tick();
      chk("er_released", 32'(u4_busy), 0);
      tick();
      chk("er_regrant_busy", 32'(u4_busy),      1);
      chk("er_next_grant0",  32'(u4_req_ready), 32'b0001);
      tick();
      chk("er_beat_data", 32'(u4_out_data), 32'h80);
      chk("er_beat_src",  32'(u4_out_src),  0);

      // ena low mid-burst with a pending output beat
      ena = 1'b0; out_ready = 1'b0;
      #1;
      chk("ena_ready_off", 32'(u4_req_ready), 0);
      tick();
      chk("ena_busy_drop", 32'(u4_busy),      0);
      chk("ena_held",      32'(u4_out_valid), 1);
      chk("ena_held_data", 32'(u4_out_data),  32'h80);
      out_ready = 1'b1;
      #1;
      chk("ena_ready_off2", 32'(u4_req_ready), 0);
      tick();
      chk("ena_drained",    32'(u4_out_valid), 0);
      chk("ena_no_grant",   32'(u4_busy),      0);
      tick();
      chk("ena_no_grant2",  32'(u4_busy),      0);

      // reset mid-burst (rr_ptr is 1 here, so requester 1 is granted)
      ena = 1'b1;
      tick();
      chk("rmb_busy", 32'(u4_busy), 1);
      tick();
      chk("rmb_pre_valid", 32'(u4_out_valid), 1);
      chk("rmb_pre_data",  32'(u4_out_data),  32'h90);
      chk("rmb_pre_src",   32'(u4_out_src),   1);
      rst = 1'b1; out_ready = 1'b0;
      tick();
      chk("rmb_out_valid", 32'(u4_out_valid), 0);
      chk("rmb_busy_off",  32'(u4_busy),      0);
      chk("rmb_out_data",  32'(u4_out_data),  0);
      rst = 1'b0;
      tick();
      chk("rmb_regrant",  32'(u4_busy),      1);
      chk("rmb_grant0",   32'(u4_req_ready), 32'b0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tt_output_arbiter.md
Name: tt_output_arbiter

Overview:
- Round-robin arbiter sharing the 8-bit dedicated output bus between N_REQ internal requesters; each requester has a valid/ready handshake.
- The granted requester keeps the bus for a burst of up to MAX_BURST beats, then priority rotates.
- A registered output stage drives the top-level uo_out path, with a downstream ready (out_ready) for backpressure.
- Gated by the tile design enable (ena): no new grants and no new beats while ena is low.

Parameters:
- N_REQ, 4, number of requesters (1..8).
- DATA_W, 8, beat width in bits.
- MAX_BURST, 4, maximum beats per grant (1..255).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  design enable; low blocks new grants and transfers.
- req_valid  input  N_REQ  per-requester beat valid.
- req_data  input  N_REQ*DATA_W  flattened beats; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  N_REQ  per-requester accept; beat transfers when valid&ready.
- out_valid  output  1  output register holds an unconsumed beat.
- out_data  output  DATA_W  output beat.
- out_src  output  max(1,clog2(N_REQ))  index of the requester that produced out_data.
- out_ready  input  1  downstream accepts out_data when out_valid&out_ready.
- busy  output  1  high while in BUSY state.

Behaviour:
- Reset (rst=1 at a clock edge) sets: state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, out_valid=0, out_data=0, out_src=0, busy=0. req_ready is combinationally 0 while in IDLE.
- Reset mid-burst discards the output register contents; no beat survives reset.
- States:
  - IDLE: if ena=1 and any req_valid=1, pick the first index at or after rr_ptr (cyclic) with req_valid set. Latch it as grant, clear beat_cnt, go to BUSY.
  - BUSY: req_ready[grant] = ena & (!out_valid | out_ready). All other req_ready bits are 0.
- Transfer (req_valid[grant] & req_ready[grant]):
  - Load out_data=req_data[grant], out_src=grant, out_valid=1; beat_cnt+1.
  - If this is beat number MAX_BURST, go to IDLE with rr_ptr=(grant+1) mod N_REQ.
- Early release: in BUSY with req_valid[grant]=0, go to IDLE, rr_ptr=(grant+1) mod N_REQ, no transfer.
- ena low in BUSY: go to IDLE, rr_ptr=(grant+1) mod N_REQ, no transfer.
  - An already-loaded out_valid beat is held and still drains via out_ready regardless of ena.
- Output register:
  - out_valid clears on out_ready when no new load occurs that cycle.
  - A simultaneous drain and load keeps out_valid=1 with the new data (full throughput, one beat per cycle).
  - out_data/out_src stay stable while out_valid=1 and out_ready=0.
- Latency: a request first seen in IDLE at edge t gives BUSY at t+1, req_ready high during cycle t+1, and the beat on out_data after edge t+2. Each grant costs one arbitration cycle.
- Backpressure: stalled cycles do not advance beat_cnt.
- Wrap-around: rr_ptr rolls from N_REQ-1 to 0.
- Boundaries:
  - N_REQ=1: always grant 0.
  - MAX_BURST=1: rotate after every beat.
- Simultaneous requests resolve strictly by rotating priority; no requester is starved beyond (N_REQ-1) bursts.
- beat_cnt width is clog2(MAX_BURST+1). rr_ptr and grant are out_src width; all modulo arithmetic wraps at N_REQ, not at the power of two.

Decomposition:
- Package tt_arb_pkg:
  - state enum {IDLE, BUSY};
  - function idx_w(n) returning max(1,clog2(n));
  - default parameter constants.
- Sub-module rr_pick: combinational, takes req vector and rr_ptr, outputs found and index (rotating-priority first-set search). The arbiter FSM, counter and output register stay in tt_output_arbiter.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then all req_valid=0.
  - Required: out_valid=0, out_data=0, busy=0, req_ready=0 for 10 cycles.
- Single requester burst:
  - Stimulus: req 2 valid with data 0xA0..0xA5, out_ready=1, MAX_BURST=4.
  - Required: out carries 0xA0..0xA3 with out_src=2, then a 1-cycle gap (re-arbitration), then 0xA4, 0xA5.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously valid, data=0x10*i+beat, MAX_BURST=2.
  - Required: out_src sequence is 0,0,1,1,2,2,3,3,0,0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles mid-burst from req 1.
  - Required: out_data frozen, req_ready[1]=0, beat_cnt unchanged; no beat lost or duplicated after out_ready returns.
- Early release and ena:
  - Stimulus: req 3 drops valid after 1 beat.
  - Required: returns to IDLE and the next grant goes to 0.
  - Stimulus: ena low mid-burst.
  - Required: no further req_ready, the pending out beat still drains.
- Reset mid-burst:
  - Stimulus: rst=1 while busy=1 and out_valid=1.
  - Required: next cycle out_valid=0, busy=0, and the first grant after reset starts at requester 0.
